// File: rtl/div_pkg.sv
// Shared types and defaults for the serial divider family.
package div_pkg;

  localparam int unsigned DIV_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference if it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W_DEFAULT
) (
  input  logic [W-1:0] rIn,
  input  logic         qMsb,
  input  logic [W-1:0] d,
  output logic [W-1:0] rNext,
  output logic         qBit
);

  logic [W:0] s;
  logic [W:0] t;

  // Trial subtraction at W+1 bits; the borrow (MSB) selects restore or keep.
  always_comb begin
    s = {rIn, qMsb};
    t = s - {1'b0, d};
    if (!t[W]) begin
      rNext = t[W-1:0];
      qBit  = 1'b1;
    end else begin
      // Restoring: s < d here, so s fits in W bits.
      rNext = s[W-1:0];
      qBit  = 1'b0;
    end
  end

endmodule

// File: rtl/div_serial.sv
// Sequential restoring divider, one quotient bit per clock, with the
// start/busy/done level handshake shared with the serial multiplier.
module div_serial
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(W + 1);

  state_t state;
  state_t stateNext;

  // Partial remainder is held at W bits: R < D is invariant, so the
  // (W+1)-th bit of R is always zero and only exists inside div_step.
  logic [W-1:0]  rReg;
  logic [W-1:0]  qReg;
  logic [W-1:0]  dReg;
  logic [CW-1:0] cnt;
  logic          dzFlag;

  logic [W-1:0]  rStep;
  logic          qBit;
  logic [W-1:0]  qStep;
  logic          lastStep;

  div_step #(
    .W (W)
  ) uStep (
    .rIn   (rReg),
    .qMsb  (qReg[W-1]),
    .d     (dReg),
    .rNext (rStep),
    .qBit  (qBit)
  );

  assign qStep    = {qReg[W-2:0], qBit};
  assign lastStep = (cnt == CW'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (lastStep) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rReg      <= '0;
      qReg      <= '0;
      dReg      <= '0;
      cnt       <= '0;
      dzFlag    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dzFlag    <= 1'b1;
            end else begin
              qReg <= dividend;
              rReg <= '0;
              dReg <= divisor;
              cnt  <= CW'(W);
            end
          end
        end
        RUN: begin
          rReg <= rStep;
          qReg <= qStep;
          cnt  <= cnt - CW'(1);
          if (lastStep) begin
            quotient  <= qStep;
            remainder <= rStep;
            dzFlag    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    busy        = (state == RUN);
    done        = (state == DONE);
    div_by_zero = (state == DONE) && dzFlag;
  end

endmodule
